par_to_serial: RTL and testbench
================================

# par_to_serial

Parallel-to-serial transmitter for the serial link: accepts 8-bit words through a one-entry valid/ready buffer and shifts them out MSB first, one bit per clock. When no word is pending, it fills the link with a fixed idle character. After every reset it sends a guaranteed run of idle characters so the downstream serial-to-parallel receiver can align before any data arrives. It is the transmitting end of the serial stream that the serial-to-parallel receiver decodes.

## Interface
Parameters:
- WIDTH, 8, word width; must equal 8 for this link.
- IDLE_CHAR, 8'hBC, character sent when no data is pending.
- MIN_IDLE, 4, number of idle characters forced after reset before data may be sent; range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  parallel word from the upstream producer.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  hold buffer empty; the word is accepted on an edge where valid_in && ready_out.
- data_out  output  1  serial bit, registered.
- frame_start  output  1  registered; high for the first (MSB) bit of every transmitted byte.
- sending_data  output  1  registered; high for all 8 bits of a data byte, low for idle bytes.

## Operation
- Hold buffer: one 8-bit register plus a hold_full flag. ready_out = !hold_full, combinational from the flag. The buffer is written on accept and emptied when its contents are loaded into the shifter.
- Shifter: 8-bit shift register plus a 3-bit bit counter. Each byte drives data_out for exactly 8 consecutive cycles, MSB first.
- Byte boundary: the edge on which the bit counter wraps from 7 to 0. The first rising edge after reset release is also a boundary.
  - At a boundary, the next byte is selected and loaded.
  - Its bit 7 drives data_out.
  - frame_start goes to 1.
  - sending_data reflects the source of the byte.
- FSM states:
  - INIT: every boundary loads IDLE_CHAR, whatever hold_full is, and increments the idle counter. Transition to ACTIVE on the boundary that loads the MIN_IDLE-th idle byte.
  - ACTIVE: at a boundary, load the hold buffer if hold_full is set (sending_data=1, hold_full cleared); otherwise load IDLE_CHAR (sending_data=0). ACTIVE has no exit except reset.
- Accepting a word during INIT is allowed. The word waits in the buffer until the first ACTIVE boundary.
- Accept and load never coincide: accept requires an empty buffer, load-from-buffer requires a full one. A word offered while full is not accepted; the producer holds it.
- Reset values:
  - data_out=0, frame_start=0, sending_data=0
  - hold_full=0, so ready_out=1
  - bit counter=7, idle counter=0, state=INIT
  - shifter and hold contents=0
- Reset asserted mid-byte or mid-buffer: all state returns to reset values immediately (asynchronously). The partial byte is truncated and the buffered word is discarded. The INIT idle run restarts from zero.

## Timing
- The first boundary is the first rising edge after reset deasserts. Bytes 0..MIN_IDLE-1 are always IDLE_CHAR. Byte MIN_IDLE is the first that may carry data.
- Boundaries occur every 8 cycles: edges B, B+8, B+16, and so on.
- Latency in ACTIVE, measured from the accept edge to the edge where the MSB appears on data_out: minimum 1 cycle (accepted on B+7), maximum 8 cycles (accepted on boundary B).
- ready_out goes high the cycle after the boundary that loads the buffer. Continuous valid_in therefore sustains back-to-back data bytes at 1 byte per 8 cycles with no idle gap.
- frame_start is high for exactly 1 cycle in 8. sending_data is constant across each 8-bit byte.

## Test plan
- Reset, then no valid_in for 48 cycles → data_out shows 6 consecutive 10111100 (0xBC) bytes; frame_start pulses at cycles 1, 9, 17, …; sending_data=0 throughout.
- Offer 0xA5 immediately after reset (MIN_IDLE=4) → accepted on the first edge; bytes 0–3 are 0xBC; byte 4 is 10100101 with sending_data=1; byte 5 is 0xBC.
- In ACTIVE, hold valid_in with the sequence 0x01, 0x80, 0xFF, 0x00 → four back-to-back data bytes with sending_data=1 on all 32 bits; ready_out low between each accept and the next boundary; no idle byte inserted.
- In ACTIVE, accept 0x3C on a boundary edge → MSB appears 8 cycles later; accept 0xC3 one cycle before a boundary → MSB appears 1 cycle later.
- In ACTIVE, assert reset during bit 3 of data byte 0x5A, with 0x99 held in the buffer → outputs go to 0 immediately and ready_out goes to 1; after release, 4 idle bytes are sent, then idle continues; 0x99 is never transmitted.
- Run the conductual and structural versions in parallel under the random valid_in/data_in stimulus → data_out, frame_start, sending_data and ready_out are identical every cycle.

Source files
------------

// File: rtl/par_to_serial.sv
// Parallel-to-serial link transmitter: one-entry hold buffer feeding an
// MSB-first shifter, with idle-character fill and a forced idle run after reset.
module par_to_serial #(
    parameter int         WIDTH     = 8,
    parameter logic [7:0] IDLE_CHAR = 8'hBC,
    parameter int         MIN_IDLE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             frame_start,
    output logic             sending_data
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {INIT, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       idle_cnt_q, idle_cnt_d;
    logic             data_out_q, data_out_d;
    logic             frame_start_q, frame_start_d;
    logic             sending_q, sending_d;

    logic             boundary;
    logic             accept;
    logic             load_hold;
    logic [WIDTH-1:0] next_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= INIT;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= CW'(WIDTH - 1);
            idle_cnt_q    <= '0;
            data_out_q    <= 1'b0;
            frame_start_q <= 1'b0;
            sending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            data_out_q    <= data_out_d;
            frame_start_q <= frame_start_d;
            sending_q     <= sending_d;
        end
    end

    always_comb begin
        boundary  = (bit_cnt_q == CW'(WIDTH - 1));
        accept    = valid_in && !hold_full_q;
        load_hold = boundary && (state_q == ACTIVE) && hold_full_q;
        next_byte = load_hold ? hold_q : IDLE_CHAR;

        state_d       = state_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        idle_cnt_d    = idle_cnt_q;
        bit_cnt_d     = bit_cnt_q + CW'(1);
        // shift_q holds the bits still to be sent, aligned to the MSB
        shift_d       = {shift_q[WIDTH-2:0], 1'b0};
        data_out_d    = shift_q[WIDTH-1];
        frame_start_d = 1'b0;
        sending_d     = sending_q;

        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        if (boundary) begin
            shift_d       = {next_byte[WIDTH-2:0], 1'b0};
            data_out_d    = next_byte[WIDTH-1];
            frame_start_d = 1'b1;
            sending_d     = load_hold;
            if (load_hold) begin
                hold_full_d = 1'b0;
            end
            if (state_q == INIT) begin
                idle_cnt_d = idle_cnt_q + 4'd1;
                if (idle_cnt_q == 4'(MIN_IDLE - 1)) begin
                    state_d = ACTIVE;
                end
            end
        end
    end

    assign ready_out    = !hold_full_q;
    assign data_out     = data_out_q;
    assign frame_start  = frame_start_q;
    assign sending_data = sending_q;

endmodule

// File: tb/tb_par_to_serial.sv
// Directed bench for par_to_serial: a monitor rebuilds bytes from the serial
// stream and the main sequence compares them against hand-computed expectations.
module tb_par_to_serial;
    localparam logic [7:0] IDLE     = 8'hBC;
    localparam int         MIN_IDLE = 4;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       frame_start;
    logic       sending_data;

    typedef struct {
        logic [7:0] val;
        bit         sd;
        int         start;
    } rec_t;

    rec_t q[$];
    int   cyc;
    int   n_vec;
    int   n_err;

    par_to_serial #(.WIDTH(8), .IDLE_CHAR(IDLE), .MIN_IDLE(MIN_IDLE)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .frame_start  (frame_start),
        .sending_data (sending_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Byte monitor: cycle 1 is the first edge after reset release
    initial begin
        int         nbits;
        logic [7:0] sh;
        bit         sd0;
        int         st;
        bit         started;
        nbits = 0; sh = '0; sd0 = 0; st = 0; started = 0; cyc = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                cyc = 0; started = 0; nbits = 0;
            end else begin
                cyc++;
                #1;
                if (frame_start) begin
                    if (started) check("frame_len", nbits, 8);
                    started = 1; nbits = 0; sd0 = sending_data; st = cyc;
                end else if (started) begin
                    check("sd_const", sending_data, sd0);
                    if (nbits == 8) check("frame_gap", frame_start, 1);
                end
                if (started && nbits < 8) begin
                    sh = {sh[6:0], data_out};
                    nbits++;
                    if (nbits == 8) q.push_back('{sh, sd0, st});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int next_boundary(input int a);
        int b;
        b = 1 + 8 * MIN_IDLE;
        while (b <= a) b += 8;
        return b;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        step();
        step();
        check("rst_dout", data_out, 0);
        check("rst_fs", frame_start, 0);
        check("rst_sd", sending_data, 0);
        check("rst_rdy", ready_out, 1);
        reset = 1'b0;
        q.delete();
    endtask

    task automatic pop_rec(output rec_t r);
        int guard;
        guard = 0;
        while (q.size() == 0 && guard < 200) begin
            step();
            guard++;
        end
        if (q.size() == 0) begin
            check("byte_timeout", 0, 1);
            r = '{8'h00, 1'b0, -1};
        end else begin
            r = q.pop_front();
        end
    endtask

    task automatic pop_data(output rec_t r);
        for (int i = 0; i < 20; i++) begin
            pop_rec(r);
            if (r.sd || r.start < 0) break;
            check("fill_idle", r.val, IDLE);
        end
    endtask

    task automatic send(input logic [7:0] v, output int acc);
        int guard;
        valid_in = 1'b1;
        data_in  = v;
        guard    = 0;
        while (!ready_out && guard < 100) begin
            step();
            guard++;
        end
        if (!ready_out) check("accept_timeout", 0, 1);
        acc = cyc + 1;
        step();
        check("rdy_low", ready_out, 0);
        valid_in = 1'b0;
    endtask

    task automatic expect_idle_run(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            pop_rec(r);
            check($sformatf("idle%0d_val", i), r.val, IDLE);
            check($sformatf("idle%0d_sd", i), r.sd, 0);
            check($sformatf("idle%0d_start", i), r.start, 1 + 8 * i);
        end
    endtask

    initial begin
        logic [7:0] seq [4];
        logic [7:0] exp6 [6];
        rec_t       r;
        int         a, b, l0;
        int         acc [4];
        n_vec = 0; n_err = 0;
        reset = 1'b1; valid_in = 1'b0; data_in = '0;

        // Idle only: six 0xBC bytes framed at cycles 1, 9, 17, ...
        do_reset();
        expect_idle_run(6);

        // Word offered at release waits out the idle run
        do_reset();
        valid_in = 1'b1;
        data_in  = 8'hA5;
        step();
        check("a5_rdy_low", ready_out, 0);
        check("first_fs", frame_start, 1);
        valid_in = 1'b0;
        exp6 = '{IDLE, IDLE, IDLE, IDLE, 8'hA5, IDLE};
        for (int i = 0; i < 6; i++) begin
            pop_rec(r);
            check($sformatf("a5_b%0d_val", i), r.val, exp6[i]);
            check($sformatf("a5_b%0d_sd", i), r.sd, (i == 4) ? 1 : 0);
            check($sformatf("a5_b%0d_start", i), r.start, 1 + 8 * i);
        end

        // Back-to-back data with continuous valid_in
        seq = '{8'h01, 8'h80, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) send(seq[i], acc[i]);
        l0 = next_boundary(acc[0]);
        for (int i = 1; i < 4; i++)
            check($sformatf("b2b_acc%0d", i), acc[i], l0 + 8 * (i - 1) + 1);
        for (int i = 0; i < 4; i++) begin
            pop_data(r);
            check($sformatf("b2b%0d_val", i), r.val, seq[i]);
            check($sformatf("b2b%0d_start", i), r.start, l0 + 8 * i);
        end

        // Latency extremes: accept on a boundary and one cycle before one
        while (cyc % 8 != 0) step();
        send(8'h3C, a);
        pop_data(r);
        check("lat8_val", r.val, 8'h3C);
        check("lat8_start", r.start, a + 8);
        while (cyc % 8 != 7) step();
        send(8'hC3, a);
        pop_data(r);
        check("lat1_val", r.val, 8'hC3);
        check("lat1_start", r.start, a + 1);

        // Reset mid-byte with a word held in the buffer
        send(8'h5A, a);
        send(8'h99, b);
        l0 = next_boundary(a);
        check("rst_99_acc", b, l0 + 1);
        while (cyc < l0 + 3) step();
        check("pre_rst_dout", data_out, 1);
        check("pre_rst_rdy", ready_out, 0);
        reset = 1'b1;
        #1;
        check("async_dout", data_out, 0);
        check("async_fs", frame_start, 0);
        check("async_sd", sending_data, 0);
        check("async_rdy", ready_out, 1);
        do_reset();
        expect_idle_run(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
